// File: rtl/serial_burst_seq.sv
// serial_burst_seq: word-burst sequencer between a user word interface and the
// serial duplex controller. It pops TX words into the controller's parallel input,
// pushes received words into an RX FIFO, and gates the controller enables for
// exactly len words per burst. Everything runs on the serial clock's rising edge.
module serial_burst_seq #(
  parameter int unsigned     BITS       = 8,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter int unsigned     LEN_BITS   = 4,
  parameter logic [BITS-1:0] IDLE_WORD  = '1
) (
  input  logic                serial_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic [LEN_BITS-1:0] in_len,
  input  logic [BITS-1:0]     in_tx_word,
  input  logic                in_tx_push,
  output logic                out_tx_full,
  output logic [BITS-1:0]     out_rx_word,
  input  logic                in_rx_pop,
  output logic                out_rx_empty,
  output logic                out_busy,
  output logic                out_done,
  output logic                out_underrun,
  output logic                out_overflow,
  output logic                out_enable,
  output logic [BITS-1:0]     out_parallel,
  input  logic                in_next_word,
  input  logic                in_word_finished,
  input  logic [BITS-1:0]     in_parallel
);

  localparam int unsigned    PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned    CntW    = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StRun} state_e;

  // ---------------------------------------------------------------------------
  // TX FIFO (user side pushes, sequencer pops)
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] tx_rd_q, tx_wr_q;
  logic [CntW-1:0] tx_cnt_q;
  logic            tx_empty, tx_full, tx_push, tx_pop;
  logic [BITS-1:0] tx_head;

  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_full     = (tx_cnt_q == FullCnt);
  // A push into a full FIFO is dropped even if a pop happens on the same edge.
  assign tx_push     = in_tx_push && !tx_full;
  assign tx_head     = tx_mem[tx_rd_q];
  assign out_tx_full = tx_full;

  // TX pointers and occupancy
  always_ff @(posedge serial_clk or posedge in_rst) begin
    if (in_rst) begin
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PtrW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CntW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CntW'(1);
    end
  end

  // TX storage write
  always_ff @(posedge serial_clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= in_tx_word;
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (sequencer pushes, user side pops, first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] rx_rd_q, rx_wr_q;
  logic [CntW-1:0] rx_cnt_q;
  logic            rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty     = (rx_cnt_q == '0);
  assign rx_full      = (rx_cnt_q == FullCnt);
  assign rx_pop       = in_rx_pop && !rx_empty;
  assign out_rx_empty = rx_empty;
  // Empty FIFO presents zero so the head is well defined without resetting storage.
  assign out_rx_word  = rx_empty ? '0 : rx_mem[rx_rd_q];

  // RX pointers and occupancy
  always_ff @(posedge serial_clk or posedge in_rst) begin
    if (in_rst) begin
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PtrW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CntW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CntW'(1);
    end
  end

  // RX storage write
  always_ff @(posedge serial_clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= in_parallel;
  end

  // ---------------------------------------------------------------------------
  // Burst control
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] tx_ctr_q, tx_ctr_d;
  logic [LEN_BITS-1:0] rx_ctr_q, rx_ctr_d;
  logic [BITS-1:0]     par_q, par_d;
  logic                under_q, under_d;
  logic                over_q, over_d;
  logic                done_q, done_d;

  // Burst state and datapath registers
  always_ff @(posedge serial_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      tx_ctr_q <= '0;
      rx_ctr_q <= '0;
      par_q    <= IDLE_WORD;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      tx_ctr_q <= tx_ctr_d;
      rx_ctr_q <= rx_ctr_d;
      par_q    <= par_d;
      under_q  <= under_d;
      over_q   <= over_d;
      done_q   <= done_d;
    end
  end

  // Next-state: start, per-word TX reload and per-word RX capture
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    tx_ctr_d = tx_ctr_q;
    rx_ctr_d = rx_ctr_q;
    par_d    = par_q;
    under_d  = under_q;
    over_d   = over_q;
    done_d   = 1'b0;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    case (state_q)
      StIdle: begin
        // A start with nothing to send or a zero length leaves everything untouched.
        if (in_start && (in_len != '0) && !tx_empty) begin
          len_d    = in_len;
          par_d    = tx_head;
          tx_pop   = 1'b1;
          tx_ctr_d = LEN_BITS'(1);
          rx_ctr_d = '0;
          under_d  = 1'b0;
          over_d   = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (in_next_word && (tx_ctr_q < len_q)) begin
          tx_ctr_d = tx_ctr_q + LEN_BITS'(1);
          if (!tx_empty) begin
            par_d  = tx_head;
            tx_pop = 1'b1;
          end else begin
            par_d   = IDLE_WORD;
            under_d = 1'b1;
          end
        end
        if (in_word_finished) begin
          if (!rx_full) rx_push = 1'b1;
          else          over_d  = 1'b1;
          if (rx_ctr_q == len_q - LEN_BITS'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            rx_ctr_d = rx_ctr_q + LEN_BITS'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_enable   = (state_q == StRun);
  assign out_busy     = (state_q == StRun);
  assign out_done     = done_q;
  assign out_underrun = under_q;
  assign out_overflow = over_q;
  assign out_parallel = par_q;

endmodule

// File: tb/tb_serial_burst_seq.sv
// Bench for serial_burst_seq: a falling-edge controller stand-in drives the word
// flags and IC data, a queue-based model predicts every output each cycle, and
// directed bursts pin the model with hand-computed values.
module tb_serial_burst_seq;
  localparam int unsigned BITS     = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LEN_BITS = 4;
  localparam time         PERIOD   = 10;

  logic                serial_clk = 1'b0;
  logic                in_rst = 1'b1;
  logic                in_start = 1'b0;
  logic [LEN_BITS-1:0] in_len = '0;
  logic [BITS-1:0]     in_tx_word = '0;
  logic                in_tx_push = 1'b0;
  logic                out_tx_full;
  logic [BITS-1:0]     out_rx_word;
  logic                in_rx_pop = 1'b0;
  logic                out_rx_empty, out_busy, out_done, out_underrun, out_overflow;
  logic                out_enable;
  logic [BITS-1:0]     out_parallel;
  logic                in_next_word, in_word_finished;
  logic [BITS-1:0]     in_parallel;

  int  n_tests = 0;
  int  n_fail  = 0;
  time t_start = 0;

  logic [BITS-1:0] sent_q[$];
  logic [BITS-1:0] ic_words[$];

  always #(PERIOD / 2) serial_clk = ~serial_clk;

  serial_burst_seq #(
    .BITS      (BITS),
    .FIFO_DEPTH(DEPTH),
    .LEN_BITS  (LEN_BITS),
    .IDLE_WORD ('1)
  ) dut (
    .serial_clk      (serial_clk),
    .in_rst          (in_rst),
    .in_start        (in_start),
    .in_len          (in_len),
    .in_tx_word      (in_tx_word),
    .in_tx_push      (in_tx_push),
    .out_tx_full     (out_tx_full),
    .out_rx_word     (out_rx_word),
    .in_rx_pop       (in_rx_pop),
    .out_rx_empty    (out_rx_empty),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_underrun    (out_underrun),
    .out_overflow    (out_overflow),
    .out_enable      (out_enable),
    .out_parallel    (out_parallel),
    .in_next_word    (in_next_word),
    .in_word_finished(in_word_finished),
    .in_parallel     (in_parallel)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BITS-1:0] sent_at(input int i);
    if (sent_q.size() > i) return sent_q[i];
    return 'x;
  endfunction

  // Controller stand-in: loads a word on the first falling edge after enable and
  // after each word boundary; raises both flags on falling edge k*BITS.
  initial begin
    int m;
    int k;
    m = 0;
    in_next_word = 1'b0;
    in_word_finished = 1'b0;
    in_parallel = '0;
    forever begin
      @(negedge serial_clk);
      if (!out_enable) begin
        m = 0;
        in_next_word = 1'b0;
        in_word_finished = 1'b0;
      end else begin
        in_next_word = (m > 0) && (m % BITS == 0);
        in_word_finished = in_next_word;
        if (in_word_finished) begin
          k = m / BITS;
          in_parallel = (k <= ic_words.size()) ? ic_words[k-1] : '0;
        end
        if (m == 0 || (m > 1 && (m - 1) % BITS == 0)) sent_q.push_back(out_parallel);
        m++;
      end
    end
  end

  // Behavioural model: FIFOs as queues, a burst as "words sent" / "words received"
  logic [BITS-1:0] mtx[$];
  logic [BITS-1:0] mrx[$];
  bit              m_busy, m_done, m_under, m_over;
  logic [BITS-1:0] m_par;
  int              m_len, m_sent, m_recv;

  task automatic model_reset();
    mtx.delete();
    mrx.delete();
    m_busy = 0; m_done = 0; m_under = 0; m_over = 0;
    m_par = '1;
    m_len = 0; m_sent = 0; m_recv = 0;
  endtask

  task automatic model_step();
    int tx_pre;
    int rx_pre;
    bit tx_pop;
    bit rx_push;
    tx_pre = mtx.size();
    rx_pre = mrx.size();
    tx_pop = 0;
    rx_push = 0;
    m_done = 0;
    if (!m_busy) begin
      if (in_start && in_len != 0 && tx_pre > 0) begin
        m_len = int'(in_len);
        m_par = mtx[0];
        tx_pop = 1;
        m_sent = 1; m_recv = 0;
        m_under = 0; m_over = 0;
        m_busy = 1;
      end
    end else begin
      if (in_next_word && m_sent < m_len) begin
        if (tx_pre > 0) begin
          m_par = mtx[0];
          tx_pop = 1;
        end else begin
          m_par = '1;
          m_under = 1;
        end
        m_sent++;
      end
      if (in_word_finished) begin
        if (rx_pre < DEPTH) rx_push = 1;
        else                m_over = 1;
        m_recv++;
        if (m_recv == m_len) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    if (tx_pop) void'(mtx.pop_front());
    if (in_tx_push && tx_pre < DEPTH) mtx.push_back(in_tx_word);
    if (in_rx_pop && rx_pre > 0) void'(mrx.pop_front());
    if (rx_push) mrx.push_back(in_parallel);
  endtask

  // Compare process: advance the model on each rising edge, check 1 ns later
  initial begin
    model_reset();
    forever begin
      @(posedge serial_clk);
      if (in_rst) model_reset();
      else        model_step();
      #1;
      check("busy", out_busy, m_busy);
      check("enable", out_enable, m_busy);
      check("done", out_done, m_done);
      check("underrun", out_underrun, m_under);
      check("overflow", out_overflow, m_over);
      check("parallel", out_parallel, m_par);
      check("tx_full", out_tx_full, mtx.size() == DEPTH);
      check("rx_empty", out_rx_empty, mrx.size() == 0);
      check("rx_word", out_rx_word, (mrx.size() == 0) ? '0 : mrx[0]);
    end
  end

  task automatic push_word(input logic [BITS-1:0] w);
    @(negedge serial_clk);
    in_tx_push = 1'b1;
    in_tx_word = w;
    @(posedge serial_clk);
    #1;
    in_tx_push = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge serial_clk);
    in_rx_pop = 1'b1;
    @(posedge serial_clk);
    #1;
    in_rx_pop = 1'b0;
  endtask

  task automatic start_burst(input int len);
    @(negedge serial_clk);
    in_start = 1'b1;
    in_len = LEN_BITS'(len);
    @(posedge serial_clk);
    t_start = $time;
    #1;
    in_start = 1'b0;
    in_len = '0;
  endtask

  // Returns the number of rising edges from the start edge to the done edge.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge serial_clk);
      #1;
      if (out_done) begin
        edges = int'(($time - t_start) / PERIOD);
        break;
      end
    end
    if (edges < 0) check("done_timeout", 0, 1);
  endtask

  task automatic drain_check(input string name, input logic [BITS-1:0] w);
    check(name, out_rx_word, w);
    pop_rx();
  endtask

  initial begin
    int  e;
    time t_keep;
    repeat (3) @(posedge serial_clk);
    #1;
    check("rst_parallel", out_parallel, 8'hFF);
    check("rst_rx_empty", out_rx_empty, 1);
    check("rst_rx_word", out_rx_word, 0);
    check("rst_enable", out_enable, 0);
    @(negedge serial_clk);
    in_rst = 1'b0;

    // Two-word burst
    ic_words = '{8'h81, 8'h7E};
    sent_q.delete();
    push_word(8'hA5);
    push_word(8'h3C);
    start_burst(2);
    wait_done(e);
    check("t1_done_edge", e, 17);
    check("t1_enable_low", out_enable, 0);
    check("t1_word1", sent_at(0), 8'hA5);
    check("t1_word2", sent_at(1), 8'h3C);
    drain_check("t1_rx1", 8'h81);
    drain_check("t1_rx2", 8'h7E);
    check("t1_rx_empty", out_rx_empty, 1);

    // Underrun: one word for a three-word burst
    ic_words = '{8'h11, 8'h22, 8'h33};
    sent_q.delete();
    push_word(8'h5A);
    start_burst(3);
    repeat (8) @(posedge serial_clk);
    #1;
    check("t2_underrun_r8", out_underrun, 0);
    @(posedge serial_clk);
    #1;
    check("t2_underrun_r9", out_underrun, 1);
    wait_done(e);
    check("t2_done_edge", e, 25);
    check("t2_word1", sent_at(0), 8'h5A);
    check("t2_word2", sent_at(1), 8'hFF);
    check("t2_word3", sent_at(2), 8'hFF);
    for (int i = 0; i < 3; i++) pop_rx();

    // Overflow: six words received, RX holds four
    ic_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    sent_q.delete();
    for (int i = 0; i < 4; i++) push_word(BITS'(8'hC1 + i));
    start_burst(6);
    wait_done(e);
    check("t3_done_edge", e, 49);
    check("t3_overflow", out_overflow, 1);
    for (int i = 0; i < 4; i++) drain_check("t3_rx", BITS'(i + 1));
    check("t3_rx_empty", out_rx_empty, 1);

    // Reset in the middle of word 2
    ic_words = '{8'h55, 8'h66};
    sent_q.delete();
    push_word(8'hD1);
    push_word(8'hD2);
    push_word(8'hD3);
    start_burst(2);
    repeat (12) @(posedge serial_clk);
    #2;
    in_rst = 1'b1;
    #1;
    check("t4_enable", out_enable, 0);
    check("t4_busy", out_busy, 0);
    check("t4_rx_empty", out_rx_empty, 1);
    check("t4_parallel", out_parallel, 8'hFF);
    @(posedge serial_clk);
    @(negedge serial_clk);
    in_rst = 1'b0;
    check("t4_tx_empty_idle", out_tx_full, 0);
    sent_q.delete();
    ic_words = '{8'h77};
    push_word(8'h99);
    start_burst(1);
    wait_done(e);
    check("t4_restart_edge", e, 9);
    check("t4_restart_word", sent_at(0), 8'h99);
    drain_check("t4_rx", 8'h77);

    // Zero-length start and start while busy are ignored
    ic_words = '{8'hA1, 8'hA2};
    sent_q.delete();
    push_word(8'h42);
    push_word(8'h43);
    start_burst(0);
    check("t5_len0_busy", out_busy, 0);
    start_burst(2);
    t_keep = t_start;
    repeat (2) @(posedge serial_clk);
    start_burst(5);
    t_start = t_keep;
    wait_done(e);
    check("t5_done_edge", e, 17);
    check("t5_word1", sent_at(0), 8'h42);
    check("t5_word2", sent_at(1), 8'h43);
    for (int i = 0; i < 2; i++) pop_rx();

    // Push into a full TX FIFO is dropped
    ic_words = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    sent_q.delete();
    for (int i = 0; i < 5; i++) push_word(BITS'(8'h10 + i));
    check("t6_tx_full", out_tx_full, 1);
    start_burst(5);
    wait_done(e);
    check("t6_done_edge", e, 41);
    check("t6_word4", sent_at(3), 8'h13);
    check("t6_word5", sent_at(4), 8'hFF);
    check("t6_underrun", out_underrun, 1);
    for (int i = 0; i < 4; i++) drain_check("t6_rx", BITS'(8'hB1 + i));

    repeat (2) @(posedge serial_clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
